rmii_rx_framer: RTL
===================

// Module: rmii_rx_framer
// PURPOSE
//  Receive-side RMII framer between the RMII PHY pins (rmii_rx, rmii_crs_dv) and the MAC byte receiver.
//  Hunts preamble/SFD, assembles LSB-first dibits into bytes, and resolves RMII CRS_DV toggling at end of frame.
//  Emits a byte stream with sof/eof/err qualifiers. Runs on the 50 MHz rmii_osc domain.
// PARAMETERS
//  PRE_MIN    8     minimum 01 preamble dibits before an 11 SFD dibit is accepted
//  MAX_BYTES  1522  byte count (post-SFD) above which the frame is flagged oversize
// PORTS
//  clk          in   1   50 MHz RMII reference clock (rmii_osc)
//  rst          in   1   async active-high reset
//  speed_10     in   1   1 = 10 Mb/s (sample every 10th clk); 0 = 100 Mb/s (sample every clk)
//  rmii_rx      in   2   RMII receive dibit, bit0 first on wire
//  rmii_crs_dv  in   1   RMII carrier sense / data valid
//  rx_data      out  8   assembled byte
//  rx_valid     out  1   1-clk strobe: rx_data valid
//  rx_sof       out  1   asserted with rx_valid of the first byte after SFD
//  rx_eof       out  1   1-clk end-of-frame strobe, never coincident with rx_valid
//  rx_err       out  1   valid with rx_eof: dribble | oversize (| crc, see CONFIGURATION)
//  rx_bytes     out  11  bytes delivered in the frame; valid with rx_eof, saturates at 2047
//  rx_active    out  1   high in PRE or DATA state
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; sample counter 0; byte/dibit counters 0.
//  - Sample strobe: every clk at 100M; at 10M a mod-10 counter strobes. The counter is forced to 0 on
//    crs_dv rise while IDLE, so the first strobe falls 5 clks later (mid-symbol). All logic below advances only on strobe.
//  - States:
//    IDLE: crs_dv=1 & rx=01 -> PRE (pre_cnt=1); crs_dv=1 & rx!=01 -> DROP.
//    PRE:  rx=01 -> pre_cnt++ (saturates at 15).
//          rx=11 & pre_cnt>=PRE_MIN -> DATA (dibit idx=0, bytes=0, first=1).
//          rx=11 & pre_cnt<PRE_MIN, or rx in {00,10} -> DROP.
//          crs_dv=0 -> IDLE, with no eof.
//    DATA: shift rx into byte bits[2i+1:2i], i = dibit idx 0..3.
//          On idx=3: rx_valid=1 one clk after the strobe; rx_sof=first; first cleared.
//          bytes++; a byte with bytes>=MAX_BYTES sets oversize and is not forwarded (no rx_valid).
//    DROP: wait for end-of-carrier (rule below) -> IDLE. No outputs are produced.
//  - End of carrier (CRS_DV toggle rule): crs_dv=0 on one strobe alone is a toggle; that dibit is still taken as data.
//    crs_dv=0 on two consecutive strobes is end of frame.
//  - DATA exit on end of frame -> IDLE. rx_eof one clk after the second low strobe; rx_bytes=bytes.
//    rx_err = (idx!=0 excluding the low dibits) | oversize.
//    The two low-strobe dibits are discarded: the toggle-low dibit is rolled back so that a clean byte boundary yields no dribble.
//  - A byte completing on the same strobe as the first low sample is delivered normally.
//  - Latency: last dibit of a byte sampled -> rx_valid on the next clk.
//  - rst mid-frame: immediate return to IDLE, no eof. Following carrier without preamble -> DROP.
//  - speed_10 change mid-frame: undefined; upstream changes it only while rx_active=0.
// CONFIGURATION
//  RMII_RX_CRC_EN defined: running CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over every delivered byte, FCS included.
//    At eof, residue != 0xC704DD7B sets rx_err.
//    Also adds output crc_err (1 bit, valid with rx_eof).
//  Undefined: no CRC logic, no crc_err port; rx_err = dribble | oversize only.
// TESTING
//  1. 100M, 7x55 + D5 preamble, 64-byte frame 00..3F, clean end -> 64 rx_valid (data 00..3F).
//     sof with byte 00; eof with rx_bytes=64, rx_err=0.
//  2. Same frame, crs_dv toggling 0/1 for the last 4 dibits before the final low -> identical output to test 1.
//  3. Frame ending 2 dibits into byte 65 -> 64 bytes delivered; eof with rx_bytes=64, rx_err=1 (dribble).
//  4. Preamble of only 3 dibits 01 then 11 -> DROP; no rx_valid/eof. Next good frame is received correctly.
//  5. 1530-byte frame -> 1522 rx_valid; eof with rx_bytes=1530, rx_err=1.
//  6. 10M, frame of test 1 at 10 clks/dibit with rst pulsed at byte 20 -> 20 bytes then silence, no eof.
//     Next frame is fully received; with RMII_RX_CRC_EN, a corrupted FCS byte gives crc_err=1.

Source files
------------

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: finds the preamble and SFD, packs LSB-first dibits into bytes, and resolves CRS_DV toggling at end of frame.
// Latency: the last dibit of a byte is sampled on a strobe and rx_valid follows one clk later. rx_eof follows the second low strobe by one clk.
// Backpressure: none. Bytes are pushed out as they arrive. Define RMII_RX_CRC_EN to add the CRC-32 check and the crc_err output.
module rmii_rx_framer #(
    parameter int PRE_MIN   = 8,
    parameter int MAX_BYTES = 1522
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        speed_10,
    input  logic [1:0]  rmii_rx,
    input  logic        rmii_crs_dv,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic [10:0] rx_bytes,
    output logic        rx_active
`ifdef RMII_RX_CRC_EN
    ,
    output logic        crc_err
`endif
);

    localparam logic [3:0]  LP_PRE_MIN = 4'(PRE_MIN);
    localparam logic [10:0] LP_MAX     = 11'(MAX_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    state_t      r_state;
    logic [3:0]  r_samp_cnt;
    logic        r_crs_q;
    logic [3:0]  r_pre_cnt;
    logic [1:0]  r_idx;
    logic [1:0]  r_idx_pre;
    logic [5:0]  r_shift;
    logic [10:0] r_bytes;
    logic        r_first;
    logic        r_low;
    logic        r_oversize;

    logic        w_rise;
    logic        w_stb;
    logic [7:0]  w_byte;
    logic        w_crc_bad;

    // A carrier rise seen in IDLE re-phases the 10M sampler so that sampling lands mid-symbol.
    assign w_rise    = (r_state == S_IDLE) && rmii_crs_dv && !r_crs_q;
    assign w_stb     = speed_10 ? ((r_samp_cnt == 4'd4) && !w_rise) : 1'b1;
    assign w_byte    = {rmii_rx, r_shift};
    assign rx_active = (r_state == S_PRE) || (r_state == S_DATA);

`ifdef RMII_RX_CRC_EN
    logic [31:0] r_crc;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // 0xDEBB20E3 is the bit-reflected register image of the 0xC704DD7B good-frame residue.
    assign w_crc_bad = (r_crc != 32'hDEBB20E3);
`else
    assign w_crc_bad = 1'b0;
`endif

    // Mod-10 sample counter and carrier history used for 10M strobing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp_cnt <= 4'd0;
            r_crs_q    <= 1'b0;
        end else begin
            r_crs_q <= rmii_crs_dv;
            if (w_rise || r_samp_cnt == 4'd9) begin
                r_samp_cnt <= 4'd0;
            end else begin
                r_samp_cnt <= r_samp_cnt + 4'd1;
            end
        end
    end

    // Framing FSM: preamble hunt, byte assembly, end-of-carrier resolution and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pre_cnt  <= 4'd0;
            r_idx      <= 2'd0;
            r_idx_pre  <= 2'd0;
            r_shift    <= 6'd0;
            r_bytes    <= 11'd0;
            r_first    <= 1'b0;
            r_low      <= 1'b0;
            r_oversize <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            rx_eof     <= 1'b0;
            rx_err     <= 1'b0;
            rx_bytes   <= 11'd0;
`ifdef RMII_RX_CRC_EN
            r_crc      <= 32'hFFFFFFFF;
            crc_err    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            if (w_stb) begin
                case (r_state)
                    S_IDLE: begin
                        r_low <= 1'b0;
                        if (rmii_crs_dv) begin
                            if (rmii_rx == 2'b01) begin
                                r_state   <= S_PRE;
                                r_pre_cnt <= 4'd1;
                            end else begin
                                r_state <= S_DROP;
                            end
                        end
                    end
                    S_PRE: begin
                        if (!rmii_crs_dv) begin
                            r_state <= S_IDLE;
                        end else if (rmii_rx == 2'b01) begin
                            if (r_pre_cnt != 4'd15) r_pre_cnt <= r_pre_cnt + 4'd1;
                        end else if (rmii_rx == 2'b11 && r_pre_cnt >= LP_PRE_MIN) begin
                            r_state    <= S_DATA;
                            r_idx      <= 2'd0;
                            r_bytes    <= 11'd0;
                            r_first    <= 1'b1;
                            r_low      <= 1'b0;
                            r_oversize <= 1'b0;
`ifdef RMII_RX_CRC_EN
                            r_crc      <= 32'hFFFFFFFF;
`endif
                        end else begin
                            r_state <= S_DROP;
                        end
                    end
                    S_DATA: begin
                        if (!rmii_crs_dv && r_low) begin
                            // Second consecutive low: the frame is over and both low dibits are discarded.
                            r_state  <= S_IDLE;
                            rx_eof   <= 1'b1;
                            rx_bytes <= r_bytes;
                            rx_err   <= (r_idx_pre != 2'd0) || r_oversize || w_crc_bad;
`ifdef RMII_RX_CRC_EN
                            crc_err  <= w_crc_bad;
`endif
                        end else begin
                            r_low <= !rmii_crs_dv;
                            // Remember the byte position before a possible toggle-low dibit so that it can be rolled back.
                            if (!rmii_crs_dv) r_idx_pre <= (r_idx == 2'd3) ? 2'd0 : r_idx;
                            r_shift <= {rmii_rx, r_shift[5:2]};
                            r_idx   <= r_idx + 2'd1;
                            if (r_idx == 2'd3) begin
                                if (r_bytes != 11'h7FF) r_bytes <= r_bytes + 11'd1;
                                if (r_bytes >= LP_MAX) begin
                                    r_oversize <= 1'b1;
                                end else begin
                                    rx_valid <= 1'b1;
                                    rx_data  <= w_byte;
                                    rx_sof   <= r_first;
                                    r_first  <= 1'b0;
`ifdef RMII_RX_CRC_EN
                                    r_crc    <= f_crc8(r_crc, w_byte);
`endif
                                end
                            end
                        end
                    end
                    S_DROP: begin
                        if (!rmii_crs_dv) begin
                            if (r_low) r_state <= S_IDLE;
                            r_low <= 1'b1;
                        end else begin
                            r_low <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
